// File: rtl/ex_execute_if.sv
// ex_execute_if: ID -> EX -> MEM boundary bundle for the execute stage.
// Handshake: ID offers an instruction with id_valid; EX takes it on a rising
// edge where id_valid && ex_allowin. EX offers its result with ex_valid; MEM
// takes it on a rising edge where ex_valid && mem_allowin, otherwise every
// ex_* output holds. dbg_state/dbg_count expose the multiplier FSM.
interface ex_execute_if;
  // ID side
  logic        id_valid;
  logic        ex_allowin;
  logic        id_regwrite;
  logic        id_alusrc;
  logic        id_memread;
  logic        id_memwrite;
  logic        id_memtoreg;
  logic [1:0]  id_regdst;
  logic [4:0]  id_aluop;
  logic [31:0] id_rs;
  logic [4:0]  id_sa;
  logic [31:0] id_opb;
  logic [31:0] id_st_data;
  logic [4:0]  id_dest;
  logic [31:0] id_pc;
  logic        ex_flush;
  // MEM side
  logic        mem_allowin;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic [31:0] ex_hi;
  logic [31:0] ex_st_data;
  logic [4:0]  ex_dest;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_memtoreg;
  logic [1:0]  ex_regdst;
  logic        ex_br_taken;
  // Debug view of the multiplier state machine
  logic [0:0]  dbg_state;
  logic [4:0]  dbg_count;

  // Pipeline side that feeds EX and consumes its results
  modport master (
    output id_valid, id_regwrite, id_alusrc, id_memread, id_memwrite,
           id_memtoreg, id_regdst, id_aluop, id_rs, id_sa, id_opb,
           id_st_data, id_dest, id_pc, ex_flush, mem_allowin,
    input  ex_allowin, ex_valid, ex_result, ex_hi, ex_st_data, ex_dest,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_regdst,
           ex_br_taken, dbg_state, dbg_count
  );

  // The execute stage itself
  modport slave (
    input  id_valid, id_regwrite, id_alusrc, id_memread, id_memwrite,
           id_memtoreg, id_regdst, id_aluop, id_rs, id_sa, id_opb,
           id_st_data, id_dest, id_pc, ex_flush, mem_allowin,
    output ex_allowin, ex_valid, ex_result, ex_hi, ex_st_data, ex_dest,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_regdst,
           ex_br_taken, dbg_state, dbg_count
  );
endinterface

// File: rtl/ex_execute.sv
// ex_execute: MIPS execute stage. Evaluates the 5-bit ALUOp, resolves branch
// conditions, runs a signed 32x32 multiply and registers everything into the
// EX/MEM boundary under the valid/allowin handshake.
// Build option: define EX_FAST_MUL_EN for a single-cycle combinational
// multiply; by default a 32-iteration shift-add multiplier FSM is built.
module ex_execute #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  ex_execute_if.slave bus
);

  localparam logic [4:0] OP_MUL  = 5'd13;
  localparam logic [1:0] RD_LINK = 2'd2;

  // Operand selection and common handshake terms
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_pc8;
  logic        w_allowin;
  logic        w_accept;
  logic        w_ld;

  // ALU outputs
  logic [31:0] w_alu_res;
  logic [31:0] w_alu_hi;
  logic        w_br;
  logic [31:0] w_op13_lo;
  logic [31:0] w_op13_hi;

  // Values to load into the EX/MEM registers when w_ld is high
  logic [31:0] w_n_result;
  logic [31:0] w_n_hi;
  logic        w_n_br;
  logic        w_n_regwrite;
  logic        w_n_memread;
  logic        w_n_memwrite;
  logic        w_n_memtoreg;
  logic [1:0]  w_n_regdst;
  logic [4:0]  w_n_dest;
  logic [31:0] w_n_st_data;

  // EX/MEM boundary registers
  logic        r_valid;
  logic [31:0] r_result;
  logic [31:0] r_hi;
  logic        r_br;
  logic        r_regwrite;
  logic        r_memread;
  logic        r_memwrite;
  logic        r_memtoreg;
  logic [1:0]  r_regdst;
  logic [4:0]  r_dest;
  logic [31:0] r_st_data;

  assign w_a      = bus.id_alusrc ? {27'd0, bus.id_sa} : bus.id_rs;
  assign w_b      = bus.id_opb;
  assign w_pc8    = bus.id_pc + 32'd8;
  assign w_accept = bus.id_valid && w_allowin;

  // ALU, branch condition and the link-address override
  always_comb begin
    w_alu_res = 32'd0;
    w_alu_hi  = 32'd0;
    w_br      = 1'b0;
    case (bus.id_aluop)
      5'd0:  w_alu_res = w_a + w_b;
      5'd1:  w_alu_res = w_a - w_b;
      5'd2:  w_alu_res = {31'd0, ($signed(w_a) < $signed(w_b))};
      5'd3:  w_alu_res = {31'd0, (w_a < w_b)};
      5'd4:  w_alu_res = w_a & w_b;
      5'd5:  w_alu_res = ~(w_a | w_b);
      5'd6:  w_alu_res = w_a | w_b;
      5'd7:  w_alu_res = w_a ^ w_b;
      5'd8:  w_alu_res = w_b << w_a[4:0];
      5'd9:  w_alu_res = w_b >> w_a[4:0];
      5'd10: w_alu_res = $signed(w_b) >>> w_a[4:0];
      5'd11: w_alu_res = {w_b[15:0], 16'h0000};
      5'd12: w_alu_res = {w_a[31:16], w_b[15:0]};
      5'd13: begin
        w_alu_res = w_op13_lo;
        w_alu_hi  = w_op13_hi;
      end
      5'd14: begin
        w_br      = w_a[31];
        w_alu_res = w_pc8;
      end
      5'd15: begin
        w_br      = w_a[31] || (w_a == 32'd0);
        w_alu_res = w_pc8;
      end
      5'd16: begin
        w_br      = !w_a[31] && (w_a != 32'd0);
        w_alu_res = w_pc8;
      end
      5'd17: begin
        w_br      = !w_a[31];
        w_alu_res = w_pc8;
      end
      5'd18: begin
        w_br      = (w_a == w_b);
        w_alu_res = w_pc8;
      end
      5'd19: begin
        w_br      = (w_a != w_b);
        w_alu_res = w_pc8;
      end
      default: begin
        w_alu_res = 32'd0;
        w_br      = 1'b0;
      end
    endcase
    // Link destination always writes PC+8, whatever the op
    if (bus.id_regdst == RD_LINK) begin
      w_alu_res = w_pc8;
    end
  end

`ifdef EX_FAST_MUL_EN

  // Single-cycle signed product: sign-extend to 64 bits, keep the low 64
  logic [63:0] w_fast_prod;

  assign w_fast_prod  = {{32{w_a[31]}}, w_a} * {{32{w_b[31]}}, w_b};
  assign w_op13_lo    = w_fast_prod[31:0];
  assign w_op13_hi    = w_fast_prod[63:32];
  assign w_allowin    = !r_valid || bus.mem_allowin;
  assign w_ld         = w_accept;
  assign w_n_result   = w_alu_res;
  assign w_n_hi       = w_alu_hi;
  assign w_n_br       = w_br;
  assign w_n_regwrite = bus.id_regwrite;
  assign w_n_memread  = bus.id_memread;
  assign w_n_memwrite = bus.id_memwrite;
  assign w_n_memtoreg = bus.id_memtoreg;
  assign w_n_regdst   = bus.id_regdst;
  assign w_n_dest     = bus.id_dest;
  assign w_n_st_data  = bus.id_st_data;
  assign bus.dbg_state = 1'b0;
  assign bus.dbg_count = 5'd0;

`else

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_MUL    = 1'b1;
  localparam logic [4:0] LAST_CNT = 5'(MUL_CYCLES - 1);

  logic [0:0]  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_mcand;
  logic [63:0] r_prod;
  logic        r_neg;
  // Control of the multiply in flight, released when the product loads
  logic        r_p_regwrite;
  logic        r_p_memread;
  logic        r_p_memwrite;
  logic        r_p_memtoreg;
  logic [1:0]  r_p_regdst;
  logic [4:0]  r_p_dest;
  logic [31:0] r_p_st_data;
  logic [31:0] r_p_pc8;

  logic        w_is_mul;
  logic        w_done;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_sum;
  logic [63:0] w_step;
  logic [63:0] w_sprod;

  assign w_is_mul  = (bus.id_aluop == OP_MUL);
  assign w_done    = (r_state == S_MUL) && (r_cnt == LAST_CNT);
  assign w_abs_a   = w_a[31] ? (32'd0 - w_a) : w_a;
  assign w_abs_b   = w_b[31] ? (32'd0 - w_b) : w_b;
  // One shift-add step: multiplier sits in the low half and shifts out
  assign w_sum     = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_mcand} : 33'd0);
  assign w_step    = {w_sum, r_prod[31:1]};
  assign w_sprod   = r_neg ? (64'd0 - w_step) : w_step;
  assign w_op13_lo = 32'd0;
  assign w_op13_hi = 32'd0;
  assign w_allowin = (r_state == S_IDLE) && (!r_valid || bus.mem_allowin);
  assign w_ld      = (w_accept && !w_is_mul) || w_done;

  assign w_n_result   = w_done ? ((r_p_regdst == RD_LINK) ? r_p_pc8 : w_sprod[31:0])
                               : w_alu_res;
  assign w_n_hi       = w_done ? w_sprod[63:32] : w_alu_hi;
  assign w_n_br       = w_done ? 1'b0 : w_br;
  assign w_n_regwrite = w_done ? r_p_regwrite : bus.id_regwrite;
  assign w_n_memread  = w_done ? r_p_memread  : bus.id_memread;
  assign w_n_memwrite = w_done ? r_p_memwrite : bus.id_memwrite;
  assign w_n_memtoreg = w_done ? r_p_memtoreg : bus.id_memtoreg;
  assign w_n_regdst   = w_done ? r_p_regdst   : bus.id_regdst;
  assign w_n_dest     = w_done ? r_p_dest     : bus.id_dest;
  assign w_n_st_data  = w_done ? r_p_st_data  : bus.id_st_data;
  assign bus.dbg_state = r_state;
  assign bus.dbg_count = r_cnt;

  // Multiplier FSM: IDLE -> MUL on a multiply accept, 32 steps, back to IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_mcand <= 32'd0;
      r_prod  <= 64'd0;
      r_neg   <= 1'b0;
    end else if (bus.ex_flush) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_state <= S_MUL;
            r_cnt   <= 5'd0;
            r_mcand <= w_abs_a;
            r_prod  <= {32'd0, w_abs_b};
            r_neg   <= w_a[31] ^ w_b[31];
          end
        end
        S_MUL: begin
          r_prod <= w_step;
          r_cnt  <= r_cnt + 5'd1;
          if (w_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Capture the multiply's control bundle when it is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p_regwrite <= 1'b0;
      r_p_memread  <= 1'b0;
      r_p_memwrite <= 1'b0;
      r_p_memtoreg <= 1'b0;
      r_p_regdst   <= 2'd0;
      r_p_dest     <= 5'd0;
      r_p_st_data  <= 32'd0;
      r_p_pc8      <= 32'd0;
    end else if (w_accept && w_is_mul && !bus.ex_flush) begin
      r_p_regwrite <= bus.id_regwrite;
      r_p_memread  <= bus.id_memread;
      r_p_memwrite <= bus.id_memwrite;
      r_p_memtoreg <= bus.id_memtoreg;
      r_p_regdst   <= bus.id_regdst;
      r_p_dest     <= bus.id_dest;
      r_p_st_data  <= bus.id_st_data;
      r_p_pc8      <= w_pc8;
    end
  end

`endif

  // EX/MEM register: flush kills, load takes a new result, handoff drains
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_result   <= 32'd0;
      r_hi       <= 32'd0;
      r_br       <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_regdst   <= 2'd0;
      r_dest     <= 5'd0;
      r_st_data  <= 32'd0;
    end else if (bus.ex_flush) begin
      r_valid <= 1'b0;
    end else if (w_ld) begin
      r_valid    <= 1'b1;
      r_result   <= w_n_result;
      r_hi       <= w_n_hi;
      r_br       <= w_n_br;
      r_regwrite <= w_n_regwrite;
      r_memread  <= w_n_memread;
      r_memwrite <= w_n_memwrite;
      r_memtoreg <= w_n_memtoreg;
      r_regdst   <= w_n_regdst;
      r_dest     <= w_n_dest;
      r_st_data  <= w_n_st_data;
    end else if (r_valid && bus.mem_allowin) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.ex_allowin  = w_allowin;
  assign bus.ex_valid    = r_valid;
  assign bus.ex_result   = r_result;
  assign bus.ex_hi       = r_hi;
  assign bus.ex_br_taken = r_br;
  assign bus.ex_regwrite = r_regwrite;
  assign bus.ex_memread  = r_memread;
  assign bus.ex_memwrite = r_memwrite;
  assign bus.ex_memtoreg = r_memtoreg;
  assign bus.ex_regdst   = r_regdst;
  assign bus.ex_dest     = r_dest;
  assign bus.ex_st_data  = r_st_data;

endmodule
